collector_i2c_target: RTL

- I2C responder (target) that is the other end of the collector I2C master bus: it answers one 7-bit address and exposes an 8-byte register bank.
- An external I2C master reads and writes the bank with an auto-incrementing pointer. The local CPU reads and writes the same bank over the 32-bit Wishbone port.
- Lets an FPGA node act as a sensor-like peripheral on the observer I2C bus.

---
 rtl/collector_i2c_pkg.sv | 24 ++
 rtl/i2c_bus_cond.sv | 43 ++++
 rtl/collector_i2c_target.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/collector_i2c_pkg.sv
// Shared types and constants for the collector I2C target.
package collector_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

    localparam logic       BIT_ACK       = 1'b0;
    localparam logic       BIT_NACK      = 1'b1;
    localparam logic       RW_READ       = 1'b1;
    localparam logic       SDA_IDLE      = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;
    localparam logic [6:0] DEF_I2C_ADDR  = 7'h42;

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizers plus edge, START and STOP strobes.
module i2c_bus_cond (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] hist_q, hist_d;

    always_comb begin
        meta_d = {i_scl, i_sda};
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign o_sda      = sync_q[0];
    assign o_scl_rise =  sync_q[1] & ~hist_q[1];
    assign o_scl_fall = ~sync_q[1] &  hist_q[1];
    assign o_start    = sync_q[1] & hist_q[1] &  hist_q[0] & ~sync_q[0];
    assign o_stop     = sync_q[1] & hist_q[1] & ~hist_q[0] &  sync_q[0];

endmodule

// File: rtl/collector_i2c_target.sv
// I2C target with an auto-incrementing byte register bank shared with a Wishbone port.
module collector_i2c_target
    import collector_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = DEF_I2C_ADDR,
    parameter int         NREGS    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    input  logic [4:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam int PW = $clog2(NREGS);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_cond u_bus_cond (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start),
        .o_stop     (stop)
    );

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [NREGS-1:0][7:0]   regs_q, regs_d;
    logic                    wrote_q, wrote_d;
    logic                    mack_q, mack_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    irq_q, irq_d;
    logic                    wb_ack_q, wb_ack_d;
    logic [31:0]             wb_rdt_q, wb_rdt_d;

    logic [PW-1:0] wb_sel, ptr_inc;
    logic          unused_wb_bits;

    assign wb_sel         = PW'(i_wb_adr[4:2]);
    assign ptr_inc        = ptr_q + 1'b1;
    assign unused_wb_bits = ^{i_wb_dat[31:8], i_wb_adr[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        regs_d   = regs_q;
        wrote_d  = wrote_q;
        mack_d   = mack_q;
        irq_d    = 1'b0;
        wb_ack_d = i_wb_stb & ~wb_ack_q;
        wb_rdt_d = wb_rdt_q;

        // Wishbone first so a same-cycle I2C write to the same byte overrides it.
        if (i_wb_stb && !wb_ack_q) begin
            wb_rdt_d = {24'd0, regs_q[wb_sel]};
            if (i_wb_we) regs_d[wb_sel] = i_wb_dat[7:0];
        end

        if (start) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            wrote_d = 1'b0;
        end else if (stop) begin
            state_d = ST_IDLE;
            irq_d   = wrote_q;
            wrote_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && cnt_q != BITS_PER_BYTE) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_ADDR: state_d = (shift_q[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                            ST_PTR: begin
                                ptr_d   = shift_q[PW-1:0];
                                state_d = ST_PTR_ACK;
                            end
                            default: begin
                                regs_d[ptr_q] = shift_q;
                                wrote_d       = 1'b1;
                                state_d       = ST_WDATA_ACK;
                            end
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0] == RW_READ) begin
                            state_d = ST_RDATA;
                            shift_d = regs_q[ptr_q];
                        end else begin
                            state_d = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) state_d = ST_WDATA;
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WDATA;
                        ptr_d   = ptr_inc;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == BITS_PER_BYTE - 4'd1) begin
                            cnt_d   = '0;
                            state_d = ST_RDATA_ACK;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda;
                    end else if (scl_fall) begin
                        if (mack_q == BIT_ACK) begin
                            ptr_d   = ptr_inc;
                            shift_d = regs_q[ptr_inc];
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Registered from the current state, which gives SDA one cycle of hold after SCL falls.
        sda_oe_d = (state_q inside {ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK}) ||
                   (state_q == ST_RDATA && shift_q[7] != SDA_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            regs_q   <= '0;
            wrote_q  <= 1'b0;
            mack_q   <= BIT_NACK;
            sda_oe_q <= 1'b0;
            irq_q    <= 1'b0;
            wb_ack_q <= 1'b0;
            wb_rdt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            regs_q   <= regs_d;
            wrote_q  <= wrote_d;
            mack_q   <= mack_d;
            sda_oe_q <= sda_oe_d;
            irq_q    <= irq_d;
            wb_ack_q <= wb_ack_d;
            wb_rdt_q <= wb_rdt_d;
        end
    end

    assign o_sda_oe = sda_oe_q;
    assign o_irq    = irq_q;
    assign o_wb_ack = wb_ack_q;
    assign o_wb_rdt = wb_rdt_q;

endmodule
